// File: rtl/ad1_reader.sv
`timescale 1ns/1ps
// Pmod AD1 reader: drives CS/SCLK, shifts in one 16-bit frame per ADC,
// and presents both 12-bit samples with a one-cycle valid strobe.
module ad1_reader #(
   parameter int SCLK_HALF = 3,
   parameter int QUIET     = 5
) (
   input  logic        clk,
   input  logic        rst,
   output logic        CS,
   output logic        SCLK,
   input  logic        SDATA0,
   input  logic        SDATA1,
   input  logic        measure,
   output logic [11:0] data0,
   output logic [11:0] data1,
   output logic        valid,
   output logic        busy,
   output logic        frame_err
);

   localparam int HW = $clog2(SCLK_HALF + 1);
   localparam int QW = $clog2(QUIET + 1);
   localparam logic [HW-1:0] HLAST = HW'(SCLK_HALF - 1);
   localparam logic [QW-1:0] QLAST = QW'(QUIET - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONV,
      S_QUIET
   } state_e;

   state_e        state_q, state_d;
   logic [HW-1:0] half_q, half_d;
   logic [4:0]    ph_q, ph_d;
   logic [QW-1:0] qcnt_q, qcnt_d;
   logic          cs_q, cs_d;
   logic          sclk_q, sclk_d;
   logic [14:0]   sh0_q, sh0_d;
   logic [14:0]   sh1_q, sh1_d;
   logic [11:0]   data0_q, data0_d;
   logic [11:0]   data1_q, data1_d;
   logic          ferr_q, ferr_d;
   logic          valid_q, valid_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         half_q  <= '0;
         ph_q    <= '0;
         qcnt_q  <= '0;
         cs_q    <= 1'b1;
         sclk_q  <= 1'b1;
         sh0_q   <= '0;
         sh1_q   <= '0;
         data0_q <= '0;
         data1_q <= '0;
         ferr_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         half_q  <= half_d;
         ph_q    <= ph_d;
         qcnt_q  <= qcnt_d;
         cs_q    <= cs_d;
         sclk_q  <= sclk_d;
         sh0_q   <= sh0_d;
         sh1_q   <= sh1_d;
         data0_q <= data0_d;
         data1_q <= data1_d;
         ferr_q  <= ferr_d;
         valid_q <= valid_d;
      end
   end

   // ph_q counts half-periods; even boundaries drop SCLK, odd ones raise
   // it and capture. The 16th capture feeds the output load directly.
   always_comb begin
      state_d = state_q;
      half_d  = half_q;
      ph_d    = ph_q;
      qcnt_d  = qcnt_q;
      cs_d    = cs_q;
      sclk_d  = sclk_q;
      sh0_d   = sh0_q;
      sh1_d   = sh1_q;
      data0_d = data0_q;
      data1_d = data1_q;
      ferr_d  = ferr_q;
      valid_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            cs_d   = 1'b1;
            sclk_d = 1'b1;
            if (measure) begin
               state_d = S_CONV;
               cs_d    = 1'b0;
               half_d  = '0;
               ph_d    = '0;
            end
         end
         S_CONV: begin
            if (half_q == HLAST) begin
               half_d = '0;
               ph_d   = ph_q + 5'd1;
               if (!ph_q[0]) begin
                  sclk_d = 1'b0;
               end else begin
                  sclk_d = 1'b1;
                  sh0_d  = {sh0_q[13:0], SDATA0};
                  sh1_d  = {sh1_q[13:0], SDATA1};
                  if (ph_q == 5'd31) begin
                     state_d = S_QUIET;
                     qcnt_d  = '0;
                     cs_d    = 1'b1;
                     data0_d = {sh0_q[10:0], SDATA0};
                     data1_d = {sh1_q[10:0], SDATA1};
                     ferr_d  = (|sh0_q[14:11]) | (|sh1_q[14:11]);
                     valid_d = 1'b1;
                  end
               end
            end else begin
               half_d = half_q + HW'(1);
            end
         end
         S_QUIET: begin
            cs_d   = 1'b1;
            sclk_d = 1'b1;
            if (qcnt_q == QLAST) begin
               state_d = S_IDLE;
            end else begin
               qcnt_d = qcnt_q + QW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cs_d    = 1'b1;
            sclk_d  = 1'b1;
         end
      endcase
   end

   assign CS        = cs_q;
   assign SCLK      = sclk_q;
   assign data0     = data0_q;
   assign data1     = data1_q;
   assign valid     = valid_q;
   assign busy      = (state_q != S_IDLE);
   assign frame_err = ferr_q;

endmodule

// File: tb/tb_ad1_reader.sv
`timescale 1ns/1ps
// Directed bench for ad1_reader: default-parameter instance A and a
// fastest-clock instance B, each fed by a small behavioural AD7476A model.
module tb_ad1_reader;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        csa, sclka, va, ba, fea;
   logic        sd0a = 1'b0, sd1a = 1'b0, msa = 1'b0;
   logic [11:0] d0a, d1a;
   logic        csb, sclkb, vb, bb, feb;
   logic        sd0b = 1'b0, sd1b = 1'b0, msb = 1'b0;
   logic [11:0] d0b, d1b;

   ad1_reader #(.SCLK_HALF(3), .QUIET(5)) ua (
      .clk(clk), .rst(rst), .CS(csa), .SCLK(sclka),
      .SDATA0(sd0a), .SDATA1(sd1a), .measure(msa),
      .data0(d0a), .data1(d1a), .valid(va), .busy(ba),
      .frame_err(fea)
   );

   ad1_reader #(.SCLK_HALF(1), .QUIET(1)) ub (
      .clk(clk), .rst(rst), .CS(csb), .SCLK(sclkb),
      .SDATA0(sd0b), .SDATA1(sd1b), .measure(msb),
      .data0(d0b), .data1(d1b), .valid(vb), .busy(bb),
      .frame_err(feb)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ADC models: bit 15 on CS fall; after SCLK fall n, bit 16-n.
   logic [15:0] w0a = '0, w1a = '0, w0b = '0, w1b = '0;
   int fa = 0, ra = 0, fb = 0;
   realtime tprev = 0, tlast = 0;

   always @(negedge csa) begin
      fa = 0; ra = 0;
      sd0a = w0a[15]; sd1a = w1a[15];
   end
   always @(negedge sclka) if (!csa) begin
      fa = fa + 1;
      if (fa <= 16) begin
         sd0a = w0a[16-fa]; sd1a = w1a[16-fa];
      end
   end
   always @(posedge sclka) if (!csa) ra = ra + 1;

   always @(negedge csb) begin
      fb = 0;
      sd0b = w0b[15]; sd1b = w1b[15];
   end
   always @(negedge sclkb) if (!csb) begin
      fb = fb + 1;
      tprev = tlast; tlast = $realtime;
      if (fb <= 16) begin
         sd0b = w0b[16-fb]; sd1b = w1b[16-fb];
      end
   end

   int npass = 0, ntot = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic start(input bit sel, output int t0);
      @(negedge clk);
      if (sel) msb = 1'b1; else msa = 1'b1;
      @(posedge clk); #1;
      msa = 1'b0; msb = 1'b0;
      t0 = cyc;
   endtask

   task automatic wait_v(input bit sel, input int budget, output int t);
      logic v;
      t = -1;
      v = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         v = sel ? vb : va;
         if (v) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) check("valid_seen", 32'(v), 32'd1);
   endtask

   int t0, t1, t2, t3, nv;

   initial begin
      // reset
      repeat (3) @(negedge clk);
      check("rst_cs", 32'(csa), 32'd1);
      check("rst_sclk", 32'(sclka), 32'd1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_valid", 32'(va), 32'd0);
      check("rst_busy", 32'(ba), 32'd0);
      check("rst_d0", 32'(d0a), 32'h000);
      check("rst_d1", 32'(d1a), 32'h000);
      check("rst_ferr", 32'(fea), 32'd0);
      check("rst_b_cs", 32'(csb), 32'd1);
      check("rst_b_d0", 32'(d0b), 32'h000);

      // single frame
      w0a = 16'h0AAA; w1a = 16'h0555;
      start(1'b0, t0);
      check("e0_cs", 32'(csa), 32'd0);
      check("e0_busy", 32'(ba), 32'd1);
      wait_v(1'b0, 200, t1);
      check("lat", 32'(t1 - t0), 32'd96);
      check("falls", 32'(fa), 32'd16);
      check("v_cs", 32'(csa), 32'd1);
      check("s_d0", 32'(d0a), 32'hAAA);
      check("s_d1", 32'(d1a), 32'h555);
      check("s_ferr", 32'(fea), 32'd0);
      @(posedge clk); #1;
      check("v_pulse", 32'(va), 32'd0);
      repeat (3) @(posedge clk);
      #1 check("busy_q", 32'(ba), 32'd1);
      @(posedge clk); #1;
      check("busy_fall", 32'(ba), 32'd0);

      // continuous measure
      repeat (4) @(posedge clk);
      w0a = 16'h0FFF; w1a = 16'h0000;
      @(negedge clk) msa = 1'b1;
      @(posedge clk); #1 t0 = cyc;
      wait_v(1'b0, 200, t1);
      check("c1_lat", 32'(t1 - t0), 32'd96);
      check("c1_d0", 32'(d0a), 32'hFFF);
      check("c1_d1", 32'(d1a), 32'h000);
      w0a = 16'h0001; w1a = 16'h0800;
      wait_v(1'b0, 200, t2);
      check("c2_gap", 32'(t2 - t1), 32'd102);
      check("c2_d0", 32'(d0a), 32'h001);
      check("c2_d1", 32'(d1a), 32'h800);
      w0a = 16'h07FF; w1a = 16'h0FFE;
      wait_v(1'b0, 200, t3);
      msa = 1'b0;
      check("c3_gap", 32'(t3 - t2), 32'd102);
      check("c3_d0", 32'(d0a), 32'h7FF);
      check("c3_d1", 32'(d1a), 32'hFFE);
      repeat (10) @(posedge clk);
      #1 check("c_idle", 32'(ba), 32'd0);

      // frame error, then a clean frame clears it
      w0a = 16'h0321; w1a = 16'h4123;
      start(1'b0, t0);
      wait_v(1'b0, 200, t1);
      check("fe_d0", 32'(d0a), 32'h321);
      check("fe_d1", 32'(d1a), 32'h123);
      check("fe_set", 32'(fea), 32'd1);
      repeat (8) @(posedge clk);
      w0a = 16'h0ABC; w1a = 16'h0DEF;
      start(1'b0, t0);
      wait_v(1'b0, 200, t1);
      check("fe_clr", 32'(fea), 32'd0);
      check("cl_d1", 32'(d1a), 32'hDEF);
      repeat (20) @(posedge clk);
      #1 check("hold_d0", 32'(d0a), 32'hABC);
      check("hold_v", 32'(va), 32'd0);

      // reset mid-frame, during the 9th low phase
      w0a = 16'h0F0F; w1a = 16'h00F0;
      start(1'b0, t0);
      for (int i = 0; i < 200 && fa < 9; i++) begin
         @(posedge clk); #1;
      end
      check("mid_rise8", 32'(ra), 32'd8);
      check("mid_sclk_lo", 32'(sclka), 32'd0);
      #3 rst = 1'b0;
      #1;
      check("mid_cs", 32'(csa), 32'd1);
      check("mid_sclk", 32'(sclka), 32'd1);
      check("mid_busy", 32'(ba), 32'd0);
      check("mid_d0", 32'(d0a), 32'h000);
      check("mid_d1", 32'(d1a), 32'h000);
      nv = 0;
      repeat (3) begin
         @(negedge clk);
         if (va) nv++;
      end
      rst = 1'b1;
      for (int i = 0; i < 110; i++) begin
         @(posedge clk); #1;
         if (va) nv++;
      end
      check("mid_novalid", 32'(nv), 32'd0);
      check("mid_nofalls", 32'(fa), 32'd9);
      check("mid_d0_hold", 32'(d0a), 32'h000);
      start(1'b0, t0);
      wait_v(1'b0, 200, t1);
      check("re_lat", 32'(t1 - t0), 32'd96);
      check("re_d0", 32'(d0a), 32'hF0F);
      check("re_d1", 32'(d1a), 32'h0F0);

      // SCLK_HALF=1, QUIET=1
      w0b = 16'h0765; w1b = 16'h0C3A;
      start(1'b1, t0);
      wait_v(1'b1, 100, t1);
      check("b_lat", 32'(t1 - t0), 32'd32);
      check("b_falls", 32'(fb), 32'd16);
      check("b_period", 32'(int'(tlast - tprev)), 32'd20);
      check("b_d0", 32'(d0b), 32'h765);
      check("b_d1", 32'(d1b), 32'hC3A);
      check("b_ferr", 32'(feb), 32'd0);
      @(posedge clk); #1;
      check("b_vpulse", 32'(vb), 32'd0);
      check("b_busy", 32'(bb), 32'd0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
